// File: rtl/alu_display_scheduler.sv
// alu_display_scheduler
// Latches switch operands and the operation index on button presses, drives
// them into the ALU datapath, and time-multiplexes the six datapath digit
// patterns onto one shared segment bus. Any press blanks the display for one
// full six-slot frame.
// Build option: define ALU_SCHED_DEBOUNCE_EN to insert the button debouncers;
// without it the accepted button level is the synchronized level.
module alu_display_scheduler #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] operands,
    input  logic       btn_load,
    input  logic       btn_op,
    input  logic [6:0] digit0,
    input  logic [6:0] digit1,
    input  logic [6:0] digit2,
    input  logic [6:0] digit3,
    input  logic [6:0] digit4,
    input  logic [6:0] digit5,
    output logic [1:0] op_sel,
    output logic [9:0] operands_q,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       blanking
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Parameter sanity, rejected at elaboration.
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("DEBOUNCE must be at least 1");
    end

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } state_e;

    // Bit 0 carries the load button, bit 1 the op button.
    logic [1:0] btn_meta_q, btn_sync_q;
    logic [9:0] opnd_meta_q, opnd_sync_q;
    logic [1:0] btn_acc;
    logic [1:0] btn_prev_q;
    logic [1:0] press;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [1:0]       op_sel_q;
    logic [9:0]       opnd_q;
    logic [6:0]       seg_q;
    logic [5:0]       an_q;
    logic             blanking_q;
    logic [6:0]       digit_sel;

    // Two-flop synchronizers for the raw buttons and switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            opnd_meta_q <= '0;
            opnd_sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what makes this a two-stage chain.
            btn_meta_q  <= {btn_op, btn_load};
            btn_sync_q  <= btn_meta_q;
            opnd_meta_q <= operands;
            opnd_sync_q <= opnd_meta_q;
        end
    end

`ifdef ALU_SCHED_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [1:0][DB_W-1:0] db_cnt_q;
    logic [1:0]           db_acc_q;

    // Accept a new button level only after it has been stable for DEBOUNCE
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt_q <= '0;
            db_acc_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_sync_q[i] == db_acc_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_acc_q[i] <= btn_sync_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_acc = db_acc_q;
`else
    assign btn_acc = btn_sync_q;
`endif

    // Remember the accepted level so a rising edge becomes a one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_prev_q <= '0;
        end else begin
            btn_prev_q <= btn_acc;
        end
    end

    assign press = btn_acc & ~btn_prev_q;

    // Select the datapath pattern for the digit currently being scanned.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no
        // latch is inferred for unlisted index values.
        digit_sel = digit0;
        case (idx_q)
            3'd1:    digit_sel = digit1;
            3'd2:    digit_sel = digit2;
            3'd3:    digit_sel = digit3;
            3'd4:    digit_sel = digit4;
            3'd5:    digit_sel = digit5;
            default: digit_sel = digit0;
        endcase
    end

    // SHOW/BLANK sequencer with scan divider, press handling and registered
    // display outputs (seg/an trail the state and index by one cycle).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_SHOW;
            div_q      <= '0;
            idx_q      <= '0;
            op_sel_q   <= '0;
            opnd_q     <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= 6'b111111;
            blanking_q <= 1'b0;
        end else begin
            an_q  <= 6'b111111 ^ (6'd1 << idx_q);
            seg_q <= (state_q == ST_BLANK) ? SEG_OFF : digit_sel;

            if (press[0]) begin
                opnd_q <= opnd_sync_q;
            end
            if (press[1]) begin
                op_sel_q <= op_sel_q + 2'd1;
            end

            if (|press) begin
                // A press always (re)starts a blank frame from slot 0.
                state_q    <= ST_BLANK;
                blanking_q <= 1'b1;
                div_q      <= '0;
                idx_q      <= '0;
            end else if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (idx_q == 3'd5) begin
                    idx_q <= '0;
                    if (state_q == ST_BLANK) begin
                        state_q    <= ST_SHOW;
                        blanking_q <= 1'b0;
                    end
                end else begin
                    idx_q <= idx_q + 3'd1;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign op_sel     = op_sel_q;
    assign operands_q = opnd_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign blanking   = blanking_q;

endmodule
